// File: rtl/data_table_search_bounded.sv
// Bounded linked-list search: walks a bucket chain in an external table,
// one read outstanding at a time, until the key matches, the chain ends,
// or MAX_HOPS entries have been read.
module data_table_search_bounded #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 16,
    parameter int A_WIDTH     = 8,
    parameter int CMD_WIDTH   = 2,
    parameter int MAX_HOPS    = 16,
    parameter int HOP_WIDTH   = $clog2(MAX_HOPS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [KEY_WIDTH-1:0]   task_key_i,
    input  logic [CMD_WIDTH-1:0]   task_cmd_i,
    input  logic [A_WIDTH-1:0]     task_head_ptr_i,
    input  logic                   task_head_ptr_val_i,
    input  logic                   task_valid_i,
    output logic                   task_ready_o,
    input  logic                   rd_avail_i,
    output logic                   rd_en_o,
    output logic [A_WIDTH-1:0]     rd_addr_o,
    input  logic [KEY_WIDTH-1:0]   rd_data_key_i,
    input  logic [VALUE_WIDTH-1:0] rd_data_value_i,
    input  logic [A_WIDTH-1:0]     rd_data_next_ptr_i,
    input  logic                   rd_data_next_ptr_val_i,
    input  logic                   rd_data_val_i,
    output logic [KEY_WIDTH-1:0]   result_key_o,
    output logic [VALUE_WIDTH-1:0] result_value_o,
    output logic [CMD_WIDTH-1:0]   result_cmd_o,
    output logic [1:0]             result_res_o,
    output logic [A_WIDTH-1:0]     result_addr_o,
    output logic [HOP_WIDTH-1:0]   result_hops_o,
    output logic                   result_valid_o,
    input  logic                   result_ready_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    typedef enum logic [1:0] {RES_FOUND, RES_NO_ENTRY, RES_CHAIN_LIMIT} res_e;

    localparam logic [HOP_WIDTH-1:0] HOPS_MAX = HOP_WIDTH'(MAX_HOPS);

    state_e                 state_q, state_d;
    res_e                   res_q, res_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic [A_WIDTH-1:0]     rd_addr_q, rd_addr_d;
    logic [HOP_WIDTH-1:0]   hops_q, hops_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [A_WIDTH-1:0]     match_addr_q, match_addr_d;
    logic [HOP_WIDTH-1:0]   hops_inc;

    // Next-state and datapath: latch task, issue reads, evaluate returned entries
    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        key_d        = key_q;
        cmd_d        = cmd_q;
        rd_addr_d    = rd_addr_q;
        hops_d       = hops_q;
        value_d      = value_q;
        match_addr_d = match_addr_q;
        hops_inc     = (hops_q == HOPS_MAX) ? hops_q : hops_q + HOP_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (task_valid_i) begin
                    key_d        = task_key_i;
                    cmd_d        = task_cmd_i;
                    hops_d       = '0;
                    value_d      = '0;
                    match_addr_d = '0;
                    if (!task_head_ptr_val_i) begin
                        res_d   = RES_NO_ENTRY;
                        state_d = DONE;
                    end else begin
                        rd_addr_d = task_head_ptr_i;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (rd_avail_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rd_data_val_i) begin
                    hops_d = hops_inc;
                    if (rd_data_key_i == key_q) begin
                        res_d        = RES_FOUND;
                        value_d      = rd_data_value_i;
                        match_addr_d = rd_addr_q;
                        state_d      = DONE;
                    end else if (!rd_data_next_ptr_val_i) begin
                        res_d   = RES_NO_ENTRY;
                        state_d = DONE;
                    end else if (hops_inc == HOPS_MAX) begin
                        res_d   = RES_CHAIN_LIMIT;
                        state_d = DONE;
                    end else begin
                        rd_addr_d = rd_data_next_ptr_i;
                        state_d   = REQ;
                    end
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            res_q        <= RES_FOUND;
            key_q        <= '0;
            cmd_q        <= '0;
            rd_addr_q    <= '0;
            hops_q       <= '0;
            value_q      <= '0;
            match_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            key_q        <= key_d;
            cmd_q        <= cmd_d;
            rd_addr_q    <= rd_addr_d;
            hops_q       <= hops_d;
            value_q      <= value_d;
            match_addr_q <= match_addr_d;
        end
    end

    assign task_ready_o   = (state_q == IDLE);
    assign rd_en_o        = (state_q == REQ) && rd_avail_i;
    assign rd_addr_o      = rd_addr_q;
    assign result_valid_o = (state_q == DONE);
    assign result_key_o   = key_q;
    assign result_cmd_o   = cmd_q;
    assign result_res_o   = res_q;
    assign result_hops_o  = hops_q;
    assign result_value_o = value_q;
    assign result_addr_o  = match_addr_q;

    // Tasks offered while busy are dropped; flag them in simulation
    task_valid_while_busy: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) (state_q != IDLE) |-> !task_valid_i);

endmodule

// File: tb/tb_data_table_search_bounded.sv
// Randomized scoreboard bench for data_table_search_bounded with a
// behavioural table/chain-walk reference model.
module tb_data_table_search_bounded;

    localparam int MH = 4;
    localparam int HW = $clog2(MH + 1);

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic [31:0]   task_key_i;
    logic [1:0]    task_cmd_i;
    logic [7:0]    task_head_ptr_i;
    logic          task_head_ptr_val_i;
    logic          task_valid_i;
    logic          task_ready_o;
    logic          rd_avail_i;
    logic          rd_en_o;
    logic [7:0]    rd_addr_o;
    logic [31:0]   rd_data_key_i;
    logic [15:0]   rd_data_value_i;
    logic [7:0]    rd_data_next_ptr_i;
    logic          rd_data_next_ptr_val_i;
    logic          rd_data_val_i;
    logic [31:0]   result_key_o;
    logic [15:0]   result_value_o;
    logic [1:0]    result_cmd_o;
    logic [1:0]    result_res_o;
    logic [7:0]    result_addr_o;
    logic [HW-1:0] result_hops_o;
    logic          result_valid_o;
    logic          result_ready_i;

    data_table_search_bounded #(.MAX_HOPS(MH)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .task_key_i(task_key_i), .task_cmd_i(task_cmd_i),
        .task_head_ptr_i(task_head_ptr_i), .task_head_ptr_val_i(task_head_ptr_val_i),
        .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
        .rd_avail_i(rd_avail_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .rd_data_key_i(rd_data_key_i), .rd_data_value_i(rd_data_value_i),
        .rd_data_next_ptr_i(rd_data_next_ptr_i), .rd_data_next_ptr_val_i(rd_data_next_ptr_val_i),
        .rd_data_val_i(rd_data_val_i),
        .result_key_o(result_key_o), .result_value_o(result_value_o),
        .result_cmd_o(result_cmd_o), .result_res_o(result_res_o),
        .result_addr_o(result_addr_o), .result_hops_o(result_hops_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] key;
        logic [1:0]  cmd;
        logic [1:0]  res;
        logic [15:0] value;
        logic [7:0]  addr;
        int          hops;
        int          nreads;
        bit          nohead;
    } exp_t;

    // Table contents seen by the read port
    logic [31:0] t_key  [256];
    logic [15:0] t_val  [256];
    logic [7:0]  t_next [256];
    logic        t_nv   [256];

    exp_t        exp_q[$];
    logic [7:0]  exp_addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int accept_cyc, last_data_cyc, reads_cnt;
    int avail_hold = 0, ready_hold = 0, spur_req = 0, lat_fixed = 0;
    bit outstanding = 0;
    int lat_cnt;
    logic [7:0]  out_addr;
    logic [31:0] cur_key;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Read-port availability and result backpressure
    always @(posedge clk) begin
        #1;
        if (avail_hold > 0) begin
            rd_avail_i = 1'b0;
            avail_hold--;
        end else begin
            rd_avail_i = ($urandom_range(0, 3) != 0);
        end
        if (result_valid_o && ready_hold > 0) begin
            result_ready_i = 1'b0;
            ready_hold--;
        end else begin
            result_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Table responder: checks read requests, returns data after a latency,
    // and injects stray data-valid pulses when no read is outstanding
    always @(negedge clk) begin
        if (rd_en_o) begin
            check("rd_en_only_when_avail", rd_avail_i, 1);
            check("single_outstanding", outstanding, 0);
        end
        rd_data_val_i          = 1'b0;
        rd_data_key_i          = $urandom;
        rd_data_value_i        = 16'($urandom);
        rd_data_next_ptr_i     = 8'($urandom);
        rd_data_next_ptr_val_i = 1'($urandom);
        if (outstanding) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                rd_data_val_i          = 1'b1;
                rd_data_key_i          = t_key[out_addr];
                rd_data_value_i        = t_val[out_addr];
                rd_data_next_ptr_i     = t_next[out_addr];
                rd_data_next_ptr_val_i = t_nv[out_addr];
                outstanding            = 0;
                last_data_cyc          = cyc + 1;
            end
        end else if (spur_req > 0 || $urandom_range(0, 9) == 0) begin
            if (spur_req > 0) spur_req--;
            rd_data_val_i = 1'b1;
            rd_data_key_i = cur_key;
        end
        if (rd_en_o && rst_n_i) begin
            reads_cnt++;
            outstanding = 1;
            out_addr    = rd_addr_o;
            lat_cnt     = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got addr 0x%0h expected no read", rd_addr_o);
            end else begin
                check("rd_addr", rd_addr_o, exp_addr_q.pop_front());
            end
        end
    end

    // Result monitor: pops the scoreboard on each new result, then holds it
    bit          in_res = 0;
    logic [62:0] held, cur;
    exp_t        e;
    always @(negedge clk) begin
        if (!rst_n_i) begin
            in_res = 0;
        end else if (result_valid_o) begin
            cur = {result_key_o, result_value_o, result_cmd_o, result_res_o,
                   result_addr_o, result_hops_o};
            if (!in_res) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got res %0d expected no result", result_res_o);
                end else begin
                    e = exp_q.pop_front();
                    check("res_key", result_key_o, e.key);
                    check("res_cmd", result_cmd_o, e.cmd);
                    check("res_code", result_res_o, e.res);
                    check("res_value", result_value_o, e.value);
                    check("res_addr", result_addr_o, e.addr);
                    check("res_hops", result_hops_o, e.hops);
                    check("res_reads", reads_cnt, e.nreads);
                    check("res_latency", cyc, e.nohead ? accept_cyc : last_data_cyc);
                    check("task_ready_busy", task_ready_o, 0);
                end
                in_res = 1;
                held   = cur;
            end else begin
                check("res_stable", cur, held);
            end
            if (result_ready_i) begin
                in_res = 0;
                done_cnt++;
            end
        end
    end

    task automatic issue(input logic [31:0] key, input logic [1:0] cmd, input logic [7:0] head,
                         input logic hv, input bit stall, input bit abort);
        exp_t        x;
        logic [7:0]  a;
        bit          fin;
        int          start;
        x.key = key; x.cmd = cmd; x.value = '0; x.addr = '0; x.hops = 0;
        x.nreads = 0; x.nohead = !hv; x.res = 2'd1;
        if (hv) begin
            a   = head;
            fin = 0;
            for (int n = 1; n <= MH && !fin; n++) begin
                exp_addr_q.push_back(a);
                x.hops = n; x.nreads = n;
                if (t_key[a] == key) begin
                    x.res = 2'd0; x.value = t_val[a]; x.addr = a; fin = 1;
                end else if (!t_nv[a]) begin
                    x.res = 2'd1; fin = 1;
                end else if (n == MH) begin
                    x.res = 2'd2; fin = 1;
                end else begin
                    a = t_next[a];
                end
            end
        end
        exp_q.push_back(x);
        start = done_cnt;
        @(negedge clk);
        cur_key = key;
        task_key_i = key; task_cmd_i = cmd; task_head_ptr_i = head;
        task_head_ptr_val_i = hv; task_valid_i = 1'b1;
        for (int i = 0; i < 200 && !task_ready_o; i++) @(negedge clk);
        check("task_accept_timeout", task_ready_o, 1);
        accept_cyc = cyc + 1;
        reads_cnt  = 0;
        if (stall) begin
            avail_hold = 5; spur_req = 2; ready_hold = 3;
        end
        @(posedge clk);
        #1 task_valid_i = 1'b0;
        if (abort) begin
            for (int i = 0; i < 100 && !outstanding; i++) @(negedge clk);
            check("abort_read_issued", outstanding, 1);
            @(negedge clk);
            rst_n_i = 1'b0;
            @(negedge clk);
            rst_n_i = 1'b1;
            exp_q.delete();
            exp_addr_q.delete();
            for (int i = 0; i < 8; i++) @(negedge clk);
            check("abort_idle", task_ready_o, 1);
            check("abort_no_result", result_valid_o, 0);
        end else begin
            for (int i = 0; i < 400 && done_cnt == start; i++) @(negedge clk);
            check("result_timeout", done_cnt, start + 1);
        end
    endtask

    task automatic randomize_table();
        for (int i = 0; i < 16; i++) begin
            t_key[i]  = 32'($urandom_range(0, 5));
            t_val[i]  = 16'($urandom);
            t_next[i] = 8'($urandom_range(0, 15));
            t_nv[i]   = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            t_key[i] = 32'hFFFF_FFFF; t_val[i] = '0; t_next[i] = '0; t_nv[i] = 1'b0;
        end
        rst_n_i = 1'b0; task_valid_i = 1'b0; task_key_i = '0; task_cmd_i = '0;
        task_head_ptr_i = '0; task_head_ptr_val_i = 1'b0;
        rd_avail_i = 1'b0; result_ready_i = 1'b0; rd_data_val_i = 1'b0;
        rd_data_key_i = '0; rd_data_value_i = '0; rd_data_next_ptr_i = '0;
        rd_data_next_ptr_val_i = 1'b0; cur_key = '0;
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
        check("rst_task_ready", task_ready_o, 1);
        check("rst_result_valid", result_valid_o, 0);
        check("rst_rd_en", rd_en_o, 0);
        check("rst_rd_addr", rd_addr_o, 0);
        check("rst_result_bus", {result_key_o, result_value_o, result_cmd_o,
                                 result_res_o, result_addr_o, result_hops_o}, 0);

        // No head pointer
        issue(32'h1234, 2'd1, 8'h00, 1'b0, 0, 0);

        // Chain 0x05 -> 0x09 -> 0x0C, match at 0x09, two-cycle read latency
        t_key[8'h05] = 32'h1111_0000; t_next[8'h05] = 8'h09; t_nv[8'h05] = 1'b1;
        t_key[8'h09] = 32'hCAFE_0009; t_val[8'h09] = 16'hBEEF;
        t_next[8'h09] = 8'h0C; t_nv[8'h09] = 1'b1;
        t_key[8'h0C] = 32'hABCD_000C; t_nv[8'h0C] = 1'b0;
        lat_fixed = 2;
        issue(32'hCAFE_0009, 2'd2, 8'h05, 1'b1, 0, 0);
        lat_fixed = 0;

        // Self-loop hits the hop limit
        t_key[8'h03] = 32'h5555; t_next[8'h03] = 8'h03; t_nv[8'h03] = 1'b1;
        issue(32'h6666, 2'd3, 8'h03, 1'b1, 0, 0);

        // Read-port and result stalls with stray data-valid pulses
        issue(32'hCAFE_0009, 2'd0, 8'h05, 1'b1, 1, 0);

        // Tail entry without match
        t_key[8'h07] = 32'h7777; t_nv[8'h07] = 1'b0;
        issue(32'h8888, 2'd1, 8'h07, 1'b1, 0, 0);

        // Reset while waiting on read data, then a normal task
        lat_fixed = 4;
        issue(32'hCAFE_0009, 2'd2, 8'h05, 1'b1, 0, 1);
        lat_fixed = 0;
        issue(32'hCAFE_0009, 2'd2, 8'h05, 1'b1, 0, 0);

        // Random chains over a small address space
        for (int n = 0; n < 150; n++) begin
            if (n % 20 == 0) randomize_table();
            issue(32'($urandom_range(0, 7)), 2'($urandom), 8'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), 0);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Backstop in case a bounded wait is bypassed
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
